// File: rtl/uart_tx_responder_pkg.sv
// uart_tx_responder_pkg
//   Shared constants for the bus-mapped UART transmitter: register offsets
//   (word index taken from DwAddress[3:2]), STATUS bit positions, the shift
//   engine state encoding and a helper that maps a programmed divisor to the
//   effective bit time.
package uart_tx_responder_pkg;

  // Register word offsets within the 16-byte window
  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_DIVISOR = 2'd2;
  localparam logic [1:0] OFF_RSVD    = 2'd3;

  // STATUS bit positions
  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_COUNT_LSB = 3;  // 4-bit field [6:3]
  localparam int STAT_OVF       = 8;

  // Bit written to STATUS[8] (through byte lane 1) to clear overflow
  localparam int CLR_OVF_BIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // A programmed divisor of zero still yields a one-cycle bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_responder_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO used as the UART transmit queue.
//   Ports:
//     clk, srst      clock and synchronous active-high reset
//     push, din      write request and data; accepted when not full, or when
//                    full and a pop happens in the same cycle
//     pop            read request; ignored when empty
//     dout           head entry (valid when !empty)
//     full, empty    occupancy flags
//     count          number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic do_push;
  logic do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, the slot being vacated by a simultaneous pop is the one the
  // write pointer addresses, so the push can proceed.
  assign do_push = push && (!full || do_pop);

  // Head is read asynchronously so the consumer can pop and load the entry
  // on the same edge.
  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_responder.sv
// uart_tx_responder
//   Memory-mapped 8N1 UART transmitter on the CPU data bus.
//   Register window (word offsets): 0 TXDATA (write pushes a byte),
//   1 STATUS (busy/full/empty/count/overflow; write bit 8 clears overflow),
//   2 DIVISOR (cycles per bit, byte lanes 0/1), 3 reserved.
//   Ports:
//     iCLK, iRST      clock and synchronous active-high reset
//     DwReadEnable    bus read strobe
//     DwWriteEnable   bus write strobe
//     DwByteEnable    write byte lanes
//     DwAddress       byte address
//     DwWriteData     write data
//     DwReadData      combinational read data, zero unless selected and read
//     oTx             registered serial output, idle high
//     oBusy           FIFO non-empty or a frame in progress
module uart_tx_responder
  import uart_tx_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFF20_0100,
  parameter logic [15:0] DEFAULT_DIV = 16'd434,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        DwReadEnable,
  input  logic        DwWriteEnable,
  input  logic [3:0]  DwByteEnable,
  input  logic [31:0] DwAddress,
  input  logic [31:0] DwWriteData,
  output logic [31:0] DwReadData,
  output logic        oTx,
  output logic        oBusy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- decode
  logic       sel;
  logic [1:0] off;
  logic       wr_txdata;
  logic       wr_status;
  logic       wr_div;

  assign sel       = (DwAddress[31:4] == BASE_ADDR[31:4]);
  assign off       = DwAddress[3:2];
  assign wr_txdata = DwWriteEnable && sel && (off == OFF_TXDATA) && DwByteEnable[0];
  assign wr_status = DwWriteEnable && sel && (off == OFF_STATUS);
  assign wr_div    = DwWriteEnable && sel && (off == OFF_DIVISOR);

  // Byte-address LSBs, upper write data and upper byte lanes have no role.
  logic unused_bits;
  assign unused_bits = ^{DwAddress[1:0], DwWriteData[31:16], DwByteEnable[3:2]};

  // --------------------------------------------------------------- divisor
  logic [15:0] div_val;

  for (genvar gi = 0; gi < 2; gi++) begin : g_div_lane
    logic [7:0] lane_reg;
    always_ff @(posedge iCLK) begin
      if (iRST) begin
        lane_reg <= DEFAULT_DIV[gi*8 +: 8];
      end else if (wr_div && DwByteEnable[gi]) begin
        lane_reg <= DwWriteData[gi*8 +: 8];
      end
    end
    assign div_val[gi*8 +: 8] = lane_reg;
  end

  // ------------------------------------------------------------------ FIFO
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iCLK),
    .srst  (iRST),
    .push  (wr_txdata),
    .din   (DwWriteData[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // -------------------------------------------------------------- overflow
  logic ovf_reg;
  logic ovf_next;

  always_comb begin
    ovf_next = ovf_reg;
    if (wr_status && DwByteEnable[1] && DwWriteData[CLR_OVF_BIT]) begin
      ovf_next = 1'b0;
    end
    // A byte is lost only when the FIFO stays full through this edge.
    if (wr_txdata && fifo_full && !fifo_pop) begin
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_next;
    end
  end

  // ---------------------------------------------------------- shift engine
  tx_state_t   state_reg,  state_next;
  logic [15:0] cnt_reg,    cnt_next;
  logic [2:0]  bit_reg,    bit_next;
  logic [7:0]  shift_reg,  shift_next;
  logic        tx_reg,     tx_next;

  logic        bit_end;
  logic [15:0] bit_load;

  // The counter is reloaded from the live divisor at every bit boundary, so
  // a divisor write mid-frame applies from the next bit onward.
  assign bit_end  = (cnt_reg == 16'd0);
  assign bit_load = eff_div(div_val) - 16'd1;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 16'd0;
      bit_reg   <= 3'd0;
      shift_reg <= 8'd0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    fifo_pop   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_head;
          cnt_next   = bit_load;
          tx_next    = 1'b0;
          state_next = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          tx_next    = shift_reg[0];
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = 3'd0;
          cnt_next   = bit_load;
          state_next = ST_DATA;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          cnt_next = bit_load;
          if (bit_reg == 3'd7) begin
            tx_next    = 1'b1;
            state_next = ST_STOP;
          end else begin
            tx_next    = shift_reg[0];
            shift_next = {1'b0, shift_reg[7:1]};
            bit_next   = bit_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            // Chain straight into the next start bit without an idle cycle.
            fifo_pop   = 1'b1;
            shift_next = fifo_head;
            cnt_next   = bit_load;
            tx_next    = 1'b0;
            state_next = ST_START;
          end else begin
            tx_next    = 1'b1;
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end

      default: begin
        tx_next    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign oTx   = tx_reg;
  assign oBusy = !fifo_empty || (state_reg != ST_IDLE);

  // ------------------------------------------------------------- read path
  logic [31:0] status_word;

  always_comb begin
    status_word                        = 32'd0;
    status_word[STAT_BUSY]             = oBusy;
    status_word[STAT_FULL]             = fifo_full;
    status_word[STAT_EMPTY]            = fifo_empty;
    status_word[STAT_COUNT_LSB +: 4]   = 4'(fifo_count);
    status_word[STAT_OVF]              = ovf_reg;
  end

  always_comb begin
    DwReadData = 32'd0;
    if (DwReadEnable && sel) begin
      case (off)
        OFF_STATUS:  DwReadData = status_word;
        OFF_DIVISOR: DwReadData = {16'd0, div_val};
        OFF_TXDATA:  DwReadData = 32'd0;
        OFF_RSVD:    DwReadData = 32'd0;
        default:     DwReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_responder.sv
// tb_uart_tx_responder
//   Scoreboarded bench: stimulus pushes the expected serial frames into a
//   queue; an independent line monitor decodes oTx cycle by cycle against the
//   head of that queue.
module tb_uart_tx_responder;

  localparam logic [31:0] BASE = 32'hFF20_0100;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_DV = BASE + 32'h8;
  localparam logic [31:0] A_RS = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        iRST;
  logic        DwReadEnable;
  logic        DwWriteEnable;
  logic [3:0]  DwByteEnable;
  logic [31:0] DwAddress;
  logic [31:0] DwWriteData;
  logic [31:0] DwReadData;
  logic        oTx;
  logic        oBusy;

  always #5 clk = ~clk;

  uart_tx_responder dut (
    .iCLK          (clk),
    .iRST          (iRST),
    .DwReadEnable  (DwReadEnable),
    .DwWriteEnable (DwWriteEnable),
    .DwByteEnable  (DwByteEnable),
    .DwAddress     (DwAddress),
    .DwWriteData   (DwWriteData),
    .DwReadData    (DwReadData),
    .oTx           (oTx),
    .oBusy         (oBusy)
  );

  typedef struct {
    logic [7:0] data;
    int         start_len;
    int         bit_len;
    bit         abort_ok;
  } frame_t;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Drives a write for exactly one edge; returns 1ns after that edge so
  // consecutive calls produce back-to-back bus writes.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    DwAddress     = addr;
    DwWriteData   = data;
    DwByteEnable  = be;
    DwWriteEnable = 1'b1;
    @(posedge clk);
    #1;
    DwWriteEnable = 1'b0;
    DwByteEnable  = 4'h0;
    $display("wr   addr=0x%08h data=0x%08h be=%b", addr, data, be);
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    DwAddress    = addr;
    DwReadEnable = 1'b1;
    #1;
    check32(name, DwReadData, exp);
    DwReadEnable = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input int sl, input int bl, input bit ab);
    frame_t f;
    f.data = d; f.start_len = sl; f.bit_len = bl; f.abort_ok = ab;
    exp_q.push_back(f);
  endtask

  // Counts falling-edge samples with oBusy high until it drops (bounded).
  task automatic busy_span(output int n);
    n = 0;
    while (n < 90000) begin
      @(negedge clk);
      if (!oBusy) break;
      n++;
    end
  endtask

  // ------------------------------------------------------------ line monitor
  initial begin : monitor
    frame_t     f;
    logic [9:0] pat;
    int         len;
    int         bad_b, bad_c, guard;
    bit         bad, aborted;
    forever begin
      @(negedge clk);
      if (iRST !== 1'b0 || oTx !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_frame: start bit seen at %0t, expected none", $time);
        guard = 0;
        while (oTx === 1'b0 && guard < 70000) begin @(negedge clk); guard++; end
        continue;
      end
      f = exp_q.pop_front();
      pat = {1'b1, f.data, 1'b0};
      bad = 0; aborted = 0; bad_b = 0; bad_c = 0;
      for (int b = 0; b < 10 && !aborted; b++) begin
        len = (b == 0) ? f.start_len : f.bit_len;
        for (int c = (b == 0) ? 1 : 0; c < len; c++) begin
          @(negedge clk);
          if (iRST === 1'b1) begin aborted = 1; break; end
          if (oTx !== pat[b] && !bad) begin bad = 1; bad_b = b; bad_c = c; end
        end
      end
      n_cmp++;
      if (aborted != f.abort_ok || (!aborted && bad)) begin
        n_err++;
        $display("FAIL frame_%02h: aborted=%0d bad=%0d at bit %0d cycle %0d, required aborted=%0d and exact waveform",
                 f.data, aborted, bad, bad_b, bad_c, f.abort_ok);
      end else begin
        $display("ok   frame_%02h: %s", f.data, aborted ? "cut by reset" : "waveform exact");
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin : stimulus
    int n;
    int low_cycles;
    iRST = 1'b1; DwReadEnable = 1'b0; DwWriteEnable = 1'b0;
    DwByteEnable = 4'h0; DwAddress = 32'h0; DwWriteData = 32'h0;
    repeat (3) @(posedge clk);
    #1 iRST = 1'b0;

    // Reset state
    read_check("rst_status", A_ST, 32'h0000_0004);
    read_check("rst_div", A_DV, 32'd434);
    check32("rst_tx", {31'd0, oTx}, 32'd1);
    check32("rst_busy", {31'd0, oBusy}, 32'd0);

    // Read decode
    read_check("rd_txdata_zero", A_TX, 32'h0);
    read_check("rd_rsvd_zero", A_RS, 32'h0);
    read_check("rd_unselected", BASE + 32'h10, 32'h0);
    DwAddress = A_DV; DwReadEnable = 1'b0; #1;
    check32("rd_not_enabled", DwReadData, 32'h0);

    // Divisor byte lanes: 0x01B2 -> 0x0134 -> 0xAB34 -> 0x0004
    bus_write(A_DV, 32'h0000_1234, 4'b0001);
    read_check("div_lane0", A_DV, 32'h0000_0134);
    bus_write(A_DV, 32'h0000_AB00, 4'b0010);
    read_check("div_lane1", A_DV, 32'h0000_AB34);
    bus_write(A_DV, 32'hDEAD_0004, 4'b1111);
    read_check("div_upper_zero", A_DV, 32'h0000_0004);

    // TXDATA with lane 0 disabled, and reserved write: no effect
    bus_write(A_TX, 32'h0000_0077, 4'b0010);
    bus_write(A_RS, 32'hFFFF_FFFF, 4'b1111);
    read_check("no_push_status", A_ST, 32'h0000_0004);

    // Single byte 0xA5 at DIV=4
    expect_frame(8'hA5, 4, 4, 0);
    bus_write(A_TX, 32'h0000_00A5, 4'b0001);
    read_check("a5_count1", A_ST, 32'h0000_0009);
    @(negedge clk);
    check32("a5_tx_before_pop", {31'd0, oTx}, 32'd1);
    @(negedge clk);
    check32("a5_tx_start", {31'd0, oTx}, 32'd0);
    busy_span(n);
    check32("a5_busy_cycles_from_write", n + 2, 32'd41);

    // Back-to-back 0x55, 0xFF; span measured from the first pop
    expect_frame(8'h55, 4, 4, 0);
    expect_frame(8'hFF, 4, 4, 0);
    bus_write(A_TX, 32'h0000_0055, 4'b0001);
    bus_write(A_TX, 32'h0000_00FF, 4'b0001);
    busy_span(n);
    check32("b2b_busy_cycles", n, 32'd80);

    // DIV=0 behaves as one cycle per bit
    bus_write(A_DV, 32'h0000_0000, 4'b0011);
    read_check("div_zero_read", A_DV, 32'h0);
    expect_frame(8'h96, 1, 1, 0);
    bus_write(A_TX, 32'h0000_0096, 4'b0001);
    busy_span(n);
    check32("div0_busy_cycles", n, 32'd11);

    // Halted shifter: one byte held in the start bit, then ten more writes;
    // eight fill the FIFO, the ninth and tenth are dropped.
    bus_write(A_DV, 32'h0000_FFFF, 4'b0011);
    expect_frame(8'h10, 65535, 4, 0);
    bus_write(A_TX, 32'h0000_0010, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) expect_frame(8'h20 + 8'(i), 4, 4, 0);
      bus_write(A_TX, 32'h20 + i, 4'b0001);
    end
    read_check("halt_full_ovf", A_ST, 32'h0000_0143);
    bus_write(A_ST, 32'h0000_0100, 4'b0001);
    read_check("ovf_kept_lane1_off", A_ST, 32'h0000_0143);
    bus_write(A_ST, 32'h0000_0100, 4'b0010);
    read_check("ovf_cleared", A_ST, 32'h0000_0043);
    bus_write(A_DV, 32'h0000_0004, 4'b0011);
    busy_span(n);
    repeat (2) @(negedge clk);
    check32("halt_drained_queue", exp_q.size(), 32'd0);

    // Reset in the middle of the data bits
    expect_frame(8'h3C, 4, 4, 1);
    bus_write(A_TX, 32'h0000_003C, 4'b0001);
    bus_write(A_TX, 32'h0000_00C3, 4'b0001);
    repeat (8) @(posedge clk);
    #1 iRST = 1'b1;
    @(posedge clk);
    #1 iRST = 1'b0;
    check32("midrst_tx", {31'd0, oTx}, 32'd1);
    check32("midrst_busy", {31'd0, oBusy}, 32'd0);
    read_check("midrst_status", A_ST, 32'h0000_0004);
    low_cycles = 0;
    repeat (200) begin
      @(negedge clk);
      if (oTx !== 1'b1) low_cycles++;
    end
    check32("midrst_no_residual", low_cycles, 32'd0);
    check32("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
